// File: rtl/lif_neuron_engine.sv
// Leaky integrate-and-fire neuron array.
// - Integrate adds one weight vector to a group of P membranes.
// - The time-step sweep applies leak and threshold to every group and emits a fire mask per group.
// - The clear sweep zeroes membranes and spike counts.
// Membrane state, spike counts and the threshold live in registers.
module lif_neuron_engine #(
  parameter int OUTPUT_NEURON             = 256,
  parameter int POST_NEUR_PARALLEL        = 4,
  parameter int POST_NEUR_MEM_WIDTH       = 12,
  parameter int POST_NEUR_SPIKE_CNT_WIDTH = 7,
  parameter int WEIGHT_WIDTH              = 8,
  parameter int THR_DEFAULT               = 77,
  localparam int P  = POST_NEUR_PARALLEL,
  localparam int M  = POST_NEUR_MEM_WIDTH,
  localparam int C  = POST_NEUR_SPIKE_CNT_WIDTH,
  localparam int W  = WEIGHT_WIDTH,
  localparam int G  = OUTPUT_NEURON / POST_NEUR_PARALLEL,
  localparam int GA = (G > 1) ? $clog2(G) : 1
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  input  logic           cmd_valid_i,
  output logic           cmd_ready_o,
  input  logic [1:0]     cmd_op_i,
  input  logic [GA-1:0]  cmd_group_i,
  input  logic [P*W-1:0] cmd_weights_i,
  input  logic [M-1:0]   cmd_thr_i,
  input  logic [3:0]     leak_shift_i,
  output logic           spike_valid_o,
  input  logic           spike_ready_i,
  output logic [GA-1:0]  spike_group_o,
  output logic [P-1:0]   spike_mask_o,
  output logic           busy_o,
  input  logic [GA-1:0]  cnt_rd_group_i,
  output logic [P*C-1:0] cnt_rd_data_o
);

  typedef enum logic [1:0] {S_IDLE, S_INTEG, S_SWEEP, S_CLEAR} state_e;

  localparam logic [1:0] OP_INTEG = 2'b00;
  localparam logic [1:0] OP_SWEEP = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;
  localparam logic [1:0] OP_THR   = 2'b11;
  localparam logic [GA-1:0] GRP_LAST = GA'(G - 1);
  localparam logic signed [M-1:0] MEM_MAX = {1'b0, {(M-1){1'b1}}};
  localparam logic signed [M-1:0] MEM_MIN = {1'b1, {(M-1){1'b0}}};

  state_e state_q, state_d;

  logic signed [M-1:0] mem_q [G][P];
  logic [C-1:0]        cnt_q [G][P];
  logic signed [M-1:0] thr_q;
  logic [GA-1:0]       grp_q;
  logic [P*W-1:0]      wts_q;
  logic [3:0]          leak_q;
  logic                rdy_q;
  logic                done_q;
  logic                spike_valid_q;
  logic [GA-1:0]       spike_group_q;
  logic [P-1:0]        spike_mask_q;

  logic                cmd_acc;
  logic                stall;
  logic                last_grp;
  logic signed [M-1:0] integ_mem [P];
  logic signed [M-1:0] sweep_mem [P];
  logic [C-1:0]        sweep_cnt [P];
  logic [P-1:0]        fire;

  // Clamp an (M+1)-bit intermediate to the signed M-bit membrane range.
  function automatic logic signed [M-1:0] sat_m(input logic signed [M:0] v);
    if (v[M] != v[M-1]) return v[M] ? MEM_MIN : MEM_MAX;
    return v[M-1:0];
  endfunction

  assign cmd_acc  = (state_q == S_IDLE) && rdy_q && cmd_valid_i;
  assign stall    = spike_valid_q && !spike_ready_i;
  assign last_grp = (grp_q == GRP_LAST);

  // Saturating membrane + weight for the latched integrate group.
  always_comb begin
    for (int i = 0; i < P; i++) begin
      integ_mem[i] = sat_m({mem_q[grp_q][i][M-1], mem_q[grp_q][i]} +
                           {{(M+1-W){wts_q[i*W+W-1]}}, wts_q[i*W +: W]});
    end
  end

  // Leak, threshold compare and post-fire update for the current sweep group.
  always_comb begin
    logic signed [M-1:0] cur;
    logic signed [M-1:0] leaked;
    logic signed [M:0]   diff;
    cur    = '0;
    leaked = '0;
    diff   = '0;
    fire   = '0;
    for (int i = 0; i < P; i++) begin
      cur          = mem_q[grp_q][i];
      leaked       = (leak_q == 4'd0) ? cur : cur - (cur >>> leak_q);
      diff         = {leaked[M-1], leaked} - {thr_q[M-1], thr_q};
      fire[i]      = (leaked >= thr_q);
      sweep_mem[i] = fire[i] ? sat_m(diff) : leaked;
      sweep_cnt[i] = (fire[i] && (cnt_q[grp_q][i] != '1)) ?
                     cnt_q[grp_q][i] + C'(1) : cnt_q[grp_q][i];
    end
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic. A sweep ends once the last group is processed and any spike it raised has been taken.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_acc) begin
          case (cmd_op_i)
            OP_INTEG: state_d = S_INTEG;
            OP_SWEEP: state_d = S_SWEEP;
            OP_CLEAR: state_d = S_CLEAR;
            default:  state_d = S_IDLE;
          endcase
        end
      end
      S_INTEG: state_d = S_IDLE;
      S_SWEEP: begin
        if (!stall && (done_q || (last_grp && (fire == '0)))) state_d = S_IDLE;
      end
      S_CLEAR: begin
        if (last_grp) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Neuron state, command latches and the registered spike port.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int g = 0; g < G; g++) begin
        for (int i = 0; i < P; i++) begin
          mem_q[g][i] <= '0;
          cnt_q[g][i] <= '0;
        end
      end
      thr_q         <= M'(THR_DEFAULT);
      grp_q         <= '0;
      wts_q         <= '0;
      leak_q        <= '0;
      rdy_q         <= 1'b0;
      done_q        <= 1'b0;
      spike_valid_q <= 1'b0;
      spike_group_q <= '0;
      spike_mask_q  <= '0;
    end else begin
      rdy_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (cmd_acc) begin
            grp_q  <= (cmd_op_i == OP_INTEG) ? cmd_group_i : '0;
            wts_q  <= cmd_weights_i;
            leak_q <= leak_shift_i;
            done_q <= 1'b0;
            if (cmd_op_i == OP_THR) thr_q <= cmd_thr_i;
          end
        end
        S_INTEG: begin
          for (int i = 0; i < P; i++) mem_q[grp_q][i] <= integ_mem[i];
        end
        S_SWEEP: begin
          if (!stall) begin
            spike_valid_q <= 1'b0;
            if (!done_q) begin
              for (int i = 0; i < P; i++) begin
                mem_q[grp_q][i] <= sweep_mem[i];
                cnt_q[grp_q][i] <= sweep_cnt[i];
              end
              if (fire != '0) begin
                spike_valid_q <= 1'b1;
                spike_group_q <= grp_q;
                spike_mask_q  <= fire;
              end
              if (last_grp) done_q <= 1'b1;
              else          grp_q  <= grp_q + GA'(1);
            end
          end
        end
        S_CLEAR: begin
          for (int i = 0; i < P; i++) begin
            mem_q[grp_q][i] <= '0;
            cnt_q[grp_q][i] <= '0;
          end
          if (!last_grp) grp_q <= grp_q + GA'(1);
        end
        default: ;
      endcase
    end
  end

  assign cmd_ready_o   = (state_q == S_IDLE) && rdy_q;
  assign busy_o        = (state_q != S_IDLE);
  assign spike_valid_o = spike_valid_q;
  assign spike_group_o = spike_group_q;
  assign spike_mask_o  = spike_mask_q;

  // Combinational spike-count readback of one group.
  always_comb begin
    cnt_rd_data_o = '0;
    for (int i = 0; i < P; i++) cnt_rd_data_o[i*C +: C] = cnt_q[cnt_rd_group_i][i];
  end

endmodule
